// File: rtl/select_stage_pkg.sv
// Shared types and constants for the N-way select stage: skid-buffer states
// and the error-counter width.
package select_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/nway_mux.sv
// Combinational N-way selector. An out-of-range select yields zero data and
// raises sel_err; NUM_INPUTS need not be a power of two.
module nway_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] choices,
  output logic [DATA_WIDTH-1:0]            out,
  output logic                             sel_err
);

  // Equality scan rather than a direct index so unused select codes fall
  // through to the error default instead of reading past the vector.
  always_comb begin
    out     = '0;
    sel_err = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (sel == SEL_WIDTH'(i)) begin
        out     = choices[i*DATA_WIDTH +: DATA_WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/nway_select_stage.sv
// Registered N-way select stage with a 2-entry skid buffer (main + skid),
// flush, and a saturating count of out-of-range selects.
module nway_select_stage
  import select_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 4,
  localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] choices,
  input  logic                             flush,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sel_err,
  output logic [ERR_CNT_W-1:0]             err_count
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid/data never depend on ready in the same cycle, and ready
  // is registered so there is no combinational path from out_ready to in_ready.

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   main_data, skid_data;
  logic                    main_err, skid_err;
  logic                    in_ready_q;
  logic [ERR_CNT_W-1:0]    err_cnt;

  logic [DATA_WIDTH-1:0]   mux_out;
  logic                    mux_err;
  logic                    accept, pop;
  logic                    load_main, load_skid, move_skid;
  logic                    err_inc;

  nway_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_mux (
    .sel     (sel),
    .choices (choices),
    .out     (mux_out),
    .sel_err (mux_err)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = (state != ST_EMPTY) & out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !pop) begin
          state_nxt = ST_FULL;
          load_skid = 1'b1;
        end else if (pop && !accept) begin
          state_nxt = ST_EMPTY;
        end else if (pop && accept) begin
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_nxt = ST_ONE;
          move_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (flush) begin
      state_nxt = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  assign err_inc = accept & mux_err & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_err   <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
      if (load_main) begin
        main_data <= mux_out;
        main_err  <= mux_err;
      end else if (move_skid) begin
        main_data <= skid_data;
        main_err  <= skid_err;
      end
      if (load_skid) begin
        skid_data <= mux_out;
        skid_err  <= mux_err;
      end
      if (err_inc && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state != ST_EMPTY);
  assign out_data    = out_valid ? main_data : '0;
  assign out_sel_err = out_valid ? main_err : 1'b0;
  assign err_count   = err_cnt;

endmodule

// File: tb/tb_nway_select_stage.sv
// Bench for nway_select_stage: one instance with 4 choices and one with 3,
// sharing stimulus; a queue model predicts every output each cycle.
module tb_nway_select_stage;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [1:0]   sel;
  logic [127:0] choices;
  logic         flush;
  logic         out_ready;

  logic         in_ready4, out_valid4, out_sel_err4;
  logic [31:0]  out_data4;
  logic [7:0]   err_count4;
  logic         in_ready3, out_valid3, out_sel_err3;
  logic [31:0]  out_data3;
  logic [7:0]   err_count3;

  logic         a_ready, a_valid, a_err;
  logic [31:0]  a_data;
  logic [7:0]   a_cnt;

  int           n_active;
  int           n_checks;
  int           n_fail;
  logic [32:0]  exp_q[$];
  int           exp_cnt;

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic        ordy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ready;
  } vec_t;
  vec_t vecs[6];

  nway_select_stage #(.DATA_WIDTH(32), .NUM_INPUTS(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready4),
    .sel         (sel),
    .choices     (choices),
    .flush       (flush),
    .out_valid   (out_valid4),
    .out_ready   (out_ready),
    .out_data    (out_data4),
    .out_sel_err (out_sel_err4),
    .err_count   (err_count4)
  );

  nway_select_stage #(.DATA_WIDTH(32), .NUM_INPUTS(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready3),
    .sel         (sel),
    .choices     (choices[95:0]),
    .flush       (flush),
    .out_valid   (out_valid3),
    .out_ready   (out_ready),
    .out_data    (out_data3),
    .out_sel_err (out_sel_err3),
    .err_count   (err_count3)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (n_active == 3) begin
      a_ready = in_ready3; a_valid = out_valid3; a_err = out_sel_err3;
      a_data  = out_data3; a_cnt   = err_count3;
    end else begin
      a_ready = in_ready4; a_valid = out_valid4; a_err = out_sel_err4;
      a_data  = out_data4; a_cnt   = err_count4;
    end
  end

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic logic [32:0] model_sel(logic [1:0] s);
    if (int'(s) < n_active) return {1'b0, choices[int'(s)*32 +: 32]};
    return {1'b1, 32'h0};
  endfunction

  // driver tasks
  task automatic drive(logic iv, logic [1:0] s, logic ordy, logic fl);
    in_valid  = iv;
    sel       = s;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Called at a falling edge: compare outputs with the model, then advance
  // the model across the next rising edge.
  task automatic tick();
    logic        acc, pp;
    logic [32:0] head, word;
    head = (exp_q.size() != 0) ? exp_q[0] : 33'h0;
    check("out_valid", a_valid, exp_q.size() != 0);
    check("in_ready", a_ready, exp_q.size() < 2);
    check("out_data", a_data, head[31:0]);
    check("out_sel_err", a_err, head[32]);
    check("err_count", a_cnt, exp_cnt);
    acc  = in_valid && (exp_q.size() < 2);
    pp   = out_ready && (exp_q.size() != 0);
    word = model_sel(sel);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = 0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(word);
        if (word[32] && exp_cnt < 255) exp_cnt++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    tick();
    n_active = n;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_cnt  = 0;
    n_active = 4;
    rst      = 1'b1;
    choices  = '0;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);

    // reset state with rst still high
    check("reset_valid", a_valid, 1'b0);
    check("reset_ready", a_ready, 1'b1);
    tick();
    rst = 1'b0;

    // streaming, NUM_INPUTS=4
    for (int i = 0; i < 4; i++) choices[i*32 +: 32] = 32'h1000 + i;
    vecs[0] = '{1'b1, 2'd0, 1'b1, 1'b0, 32'h0,    1'b1};
    vecs[1] = '{1'b1, 2'd1, 1'b1, 1'b1, 32'h1000, 1'b1};
    vecs[2] = '{1'b1, 2'd2, 1'b1, 1'b1, 32'h1001, 1'b1};
    vecs[3] = '{1'b1, 2'd3, 1'b1, 1'b1, 32'h1002, 1'b1};
    vecs[4] = '{1'b0, 2'd0, 1'b1, 1'b1, 32'h1003, 1'b1};
    vecs[5] = '{1'b0, 2'd0, 1'b1, 1'b0, 32'h0,    1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].iv, vecs[i].sel, vecs[i].ordy, 1'b0);
      check("vec_valid", a_valid, vecs[i].exp_valid);
      check("vec_data", a_data, vecs[i].exp_data);
      check("vec_ready", a_ready, vecs[i].exp_ready);
      tick();
    end

    // backpressure
    choices[31:0] = 32'hA; choices[63:32] = 32'hB; choices[95:64] = 32'hC;
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd2, 1'b0, 1'b0);
    check("bp_ready_low", a_ready, 1'b0);
    check("bp_hold_a", a_data, 32'hA);
    tick();
    check("bp_hold_a2", a_data, 32'hA);
    tick();
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    check("bp_deliver_a", a_data, 32'hA);
    tick();
    check("bp_deliver_b", a_data, 32'hB);
    tick();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    check("bp_deliver_c", a_data, 32'hC);
    tick();
    check("bp_drained", a_valid, 1'b0);
    tick();

    // out-of-range select, NUM_INPUTS=3
    do_reset(3);
    choices[95:0] = {32'h2222, 32'h1111, 32'h0FF0};
    drive(1'b1, 2'd3, 1'b1, 1'b0); tick();
    drive(1'b1, 2'd2, 1'b1, 1'b0);
    check("oor_data", a_data, 32'h0);
    check("oor_err", a_err, 1'b1);
    check("oor_count", a_cnt, 8'd1);
    tick();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    check("inrange_data", a_data, 32'h2222);
    check("inrange_err", a_err, 1'b0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 2'd3, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    tick();
    check("err_saturate", a_cnt, 8'd255);
    tick();

    // flush in FULL, then flush discarding a same-cycle accept
    do_reset(3);
    drive(1'b1, 2'd3, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    check("full_ready", a_ready, 1'b0);
    drive(1'b1, 2'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    check("flush_valid", a_valid, 1'b0);
    check("flush_ready", a_ready, 1'b1);
    check("flush_count", a_cnt, 8'd1);
    tick();
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    drive(1'b1, 2'd3, 1'b0, 1'b1); tick();
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    check("flush_accept_valid", a_valid, 1'b0);
    check("flush_accept_count", a_cnt, 8'd1);
    tick();

    // reset mid-stream in ONE
    do_reset(4);
    for (int i = 0; i < 4; i++) choices[i*32 +: 32] = 32'h5000 + i;
    drive(1'b1, 2'd0, 1'b0, 1'b0); tick();
    rst = 1'b1;
    drive(1'b1, 2'd1, 1'b0, 1'b0); tick();
    rst = 1'b0;
    check("rst_valid", a_valid, 1'b0);
    check("rst_ready", a_ready, 1'b1);
    check("rst_data", a_data, 32'h0);
    check("rst_count", a_cnt, 8'd0);
    drive(1'b1, 2'd2, 1'b1, 1'b0); tick();
    drive(1'b0, 2'd0, 1'b1, 1'b0);
    check("post_rst_valid", a_valid, 1'b1);
    check("post_rst_data", a_data, 32'h5002);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nway_select_stage.md
NWAY_SELECT_STAGE -- requirements
Module: nway_select_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of each choice and of out_data.
REQ-002 SHALL have parameter NUM_INPUTS, default 4, meaning the number of choices; legal range 2..16.
REQ-003 SHALL have localparam SEL_WIDTH, equal to $clog2(NUM_INPUTS), meaning the select width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, named as follows:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
REQ-005 SHALL have the remaining ports:
- in_valid  input  1  upstream offers a selection.
- in_ready  output  1  stage can accept.
- sel  input  SEL_WIDTH  choice index.
- choices  input  NUM_INPUTS x DATA_WIDTH (packed)  candidate values; index 0 is the LSB slice.
- flush  input  1  discard all held entries.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts.
- out_data  output  DATA_WIDTH  selected value.
- out_sel_err  output  1  held entry had sel >= NUM_INPUTS.
- err_count  output  8  count of accepted out-of-range selects.

Function
REQ-006 SHALL accept an input on a cycle where in_valid and in_ready are both high, capturing choices[sel] and the error flag.
REQ-007 SHALL capture zero data and set the error flag when sel >= NUM_INPUTS.
REQ-008 SHALL present accepted data on out_data with out_valid high on the cycle after acceptance (1-cycle latency).
REQ-009 SHALL sustain one transfer per cycle while out_ready stays high.
REQ-010 SHALL hold out_data and out_sel_err stable while out_valid is high and out_ready is low.
REQ-011 SHALL implement a 2-entry skid buffer (main and skid) with state EMPTY, ONE or FULL.
REQ-012 SHALL drive in_ready = (state != FULL) directly from a register, with no combinational path from out_ready.
REQ-013 SHALL make these EMPTY transitions: accept -> ONE.
REQ-014 SHALL make these ONE transitions:
- accept without out_ready -> FULL, new entry in skid;
- out_ready without accept -> EMPTY;
- both -> ONE, main replaced.
REQ-015 SHALL make these FULL transitions: out_ready -> ONE, skid moves to main; there is no accept in FULL.
REQ-016 SHALL transfer entries in FIFO order; no entry is dropped or duplicated.
REQ-017 SHALL, on flush, move to EMPTY on the next edge and discard any same-cycle accept; flush overrides all other events.
REQ-018 SHALL deassert out_valid on the cycle after flush, even if out_ready was low.
REQ-019 SHALL increment err_count once per accepted out-of-range select, saturate at 255, and not change on flush.
REQ-020 SHALL capture nothing while in_valid is high and in_ready is low; upstream holds the data.
REQ-021 SHALL output out_data = 0 while out_valid is low.

Reset
REQ-022 SHALL, while rst is high at a clock edge:
- enter EMPTY;
- drive out_valid = 0, in_ready = 1, out_data = 0, out_sel_err = 0, err_count = 0.
REQ-023 SHALL give rst priority over flush and over any handshake; an in-flight entry is discarded.
REQ-024 SHALL accept input on the first edge after rst falls.

Structure
REQ-025 SHALL place the state enum (EMPTY, ONE, FULL) and the error-counter width constant (8) in a shared package, select_stage_pkg.
REQ-026 SHALL instantiate one combinational sub-module, nway_mux (params DATA_WIDTH, NUM_INPUTS; ports sel, choices, out, sel_err), as the generalised N-way selector.
REQ-027 SHALL be written so that NUM_INPUTS need not be a power of two.

Verification
REQ-028 SHALL cover streaming at NUM_INPUTS=4, DATA_WIDTH=32, out_ready=1:
- stimulus: sel=0,1,2,3 on consecutive cycles, choices[i]=0x1000+i;
- response: out_data 0x1000..0x1003 on cycles 1..4, in_ready never low.
REQ-029 SHALL cover backpressure:
- stimulus: out_ready=0, two accepts (0xA, 0xB), third in_valid;
- response: in_ready=0 after second accept, out_data held 0xA;
- then out_ready=1 -> 0xA, 0xB, third value delivered in order.
REQ-030 SHALL cover an out-of-range select at NUM_INPUTS=3:
- stimulus: sel=3;
- response: out_data=0, out_sel_err=1, err_count=1;
- 300 such accepts -> err_count=255.
REQ-031 SHALL cover flush in FULL:
- stimulus: flush=1 with in_valid=1;
- response: next cycle out_valid=0, in_ready=1, err_count unchanged.
REQ-032 SHALL cover reset mid-stream:
- stimulus: rst=1 for one cycle in state ONE;
- response: all outputs at reset values the next cycle, and the following accept appears 1 cycle later.
